wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3: consecutive lost arbitration cycles before the buffered long-latency result forces a pipeline stall.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 pipe_we  input  1  MEM/WB-stage register write request.
REQ-005 pipe_rd  input  5  MEM/WB-stage destination register.
REQ-006 pipe_wd  input  32  MEM/WB-stage write data.
REQ-007 mdu_valid  input  1  long-latency unit result valid.
REQ-008 mdu_rd  input  5  long-latency unit destination register.
REQ-009 mdu_wd  input  32  long-latency unit write data.
REQ-010 mdu_ready  output  1  result accepted when mdu_valid and mdu_ready are both 1 at a clock edge.
REQ-011 stall  output  1  registered stall request to the pipeline front end.
REQ-012 pend_valid  output  1  buffered result awaiting writeback, for hazard detection.
REQ-013 pend_rd  output  5  destination register of the buffered result.
REQ-014 RFWr  output  1  register-file write enable.
REQ-015 A3  output  5  register-file write address.
REQ-016 WD  output  32  register-file write data.

Function
REQ-017 The block SHALL hold one buffer entry: buf_v, buf_rd, buf_wd; pend_valid = buf_v and pend_rd = buf_rd.
REQ-018 mdu_ready SHALL equal !buf_v && !rst, derived only from registered state; no accept while full, including the cycle the buffer drains.
REQ-019 An accepted mdu result with mdu_rd==0 SHALL be discarded; buf_v stays 0.
REQ-020 While stall==1, pipe_we SHALL be ignored; the pipeline re-presents the same request the next cycle.
REQ-021 Selection per cycle: pipe write if pipe_we && pipe_rd!=0 && !stall; else buffer write if buf_v; else no write.
REQ-022 pipe_we with pipe_rd==0 SHALL produce no write and SHALL not block the buffer.
REQ-023 The selected write SHALL appear registered on the next edge: RFWr=1, A3=rd, WD=data; latency exactly 1 cycle.
REQ-024 With no write selected, the next edge SHALL set RFWr=0, A3=0, WD=0.
REQ-025 A buffer write SHALL clear buf_v on the same edge.
REQ-026 WAW squash: a committed pipe write with pipe_rd==buf_rd while buf_v SHALL clear buf_v without writing the buffer entry.
REQ-027 An mdu result accepted in the same cycle as a committed pipe write to the same rd SHALL be discarded.
REQ-028 Starvation counter (width ceil(log2(STARVE_MAX+1))): increments each cycle buf_v=1 and the pipe wins; clears when buf_v=0 or the buffer writes.
REQ-029 When the counter equals STARVE_MAX, the next edge SHALL set stall=1 for exactly one cycle and clear the counter; the buffer writes during that stall cycle.
REQ-030 stall SHALL be 0 in all other cycles; at most one stall pulse per buffered entry.

Reset
REQ-031 With rst high at an edge: buf_v=0, buf_rd=0, buf_wd=0, counter=0, stall=0, RFWr=0, A3=0, WD=0; mdu_ready=0 while rst is high.
REQ-032 Reset mid-operation SHALL drop any buffered result without writing it; the first accept is possible on the first edge after rst falls.

Verification
REQ-033 Pipe only: pipe_we=1, rd=5, wd=0x11 -> next cycle RFWr=1, A3=5, WD=0x11; pipe_we=0 -> RFWr=0, A3=0, WD=0.
REQ-034 Idle pipe: mdu_valid=1, rd=7, wd=0xAB -> accepted (pend_valid=1, pend_rd=7), written the next cycle (RFWr=1, A3=7, WD=0xAB), mdu_ready returns to 1 after the write.
REQ-035 Starvation, STARVE_MAX=3: buffer rd=9 plus continuous pipe writes to rd=4 -> after 3 lost cycles stall=1 for one cycle, buffer writes A3=9, pipe request ignored that cycle and written next.
REQ-036 WAW: buffer holds rd=6 wd=0x1, pipe writes rd=6 wd=0x2 -> single write A3=6 WD=0x2, pend_valid=0, no later write of 0x1.
REQ-037 x0: pipe rd=0 with buffer rd=3 -> buffer writes A3=3 the next cycle; mdu rd=0 accept -> pend_valid stays 0, no write.
REQ-038 Reset with buffer full (rd=8) -> no write of rd=8, all outputs 0, mdu_ready=1 on the first cycle after rst deasserts.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges MEM/WB pipeline writes with a one-entry
// buffer of long-latency unit results, with WAW squash and a starvation stall.
module wb_arbiter #(
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_rd,
   input  logic [31:0] pipe_wd,
   input  logic        mdu_valid,
   input  logic [4:0]  mdu_rd,
   input  logic [31:0] mdu_wd,
   output logic        mdu_ready,
   output logic        stall,
   output logic        pend_valid,
   output logic [4:0]  pend_rd,
   output logic        RFWr,
   output logic [4:0]  A3,
   output logic [31:0] WD
);

   localparam int unsigned CntW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(STARVE_MAX);

   logic            buf_v_q, buf_v_d;
   logic [4:0]      buf_rd_q, buf_rd_d;
   logic [31:0]     buf_wd_q, buf_wd_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            stall_q, stall_d;
   logic            rfwr_q, rfwr_d;
   logic [4:0]      a3_q, a3_d;
   logic [31:0]     wd_q, wd_d;

   logic accept, pipe_win, buf_wr, squash;

   assign mdu_ready  = !buf_v_q && !rst;
   assign accept     = mdu_valid && mdu_ready;
   assign pipe_win   = pipe_we && (pipe_rd != 5'd0) && !stall_q;
   assign buf_wr     = buf_v_q && !pipe_win;
   assign squash     = pipe_win && buf_v_q && (pipe_rd == buf_rd_q);

   assign stall      = stall_q;
   assign pend_valid = buf_v_q;
   assign pend_rd    = buf_rd_q;
   assign RFWr       = rfwr_q;
   assign A3         = a3_q;
   assign WD         = wd_q;

   always_comb begin
      rfwr_d   = 1'b0;
      a3_d     = 5'd0;
      wd_d     = 32'd0;
      buf_v_d  = buf_v_q;
      buf_rd_d = buf_rd_q;
      buf_wd_d = buf_wd_q;
      cnt_d    = cnt_q;
      stall_d  = 1'b0;

      if (pipe_win) begin
         rfwr_d = 1'b1;
         a3_d   = pipe_rd;
         wd_d   = pipe_wd;
      end else if (buf_v_q) begin
         rfwr_d = 1'b1;
         a3_d   = buf_rd_q;
         wd_d   = buf_wd_q;
      end

      if (buf_wr || squash) begin
         buf_v_d = 1'b0;
      end

      // Accept only happens with the buffer empty; drop x0 and results made stale by the pipe.
      if (accept && (mdu_rd != 5'd0) && !(pipe_win && (pipe_rd == mdu_rd))) begin
         buf_v_d  = 1'b1;
         buf_rd_d = mdu_rd;
         buf_wd_d = mdu_wd;
      end

      if (!buf_v_q || buf_wr || squash) begin
         cnt_d = '0;
      end else if (cnt_q == CntMax) begin
         cnt_d   = '0;
         stall_d = 1'b1;
      end else if (pipe_win) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_v_q  <= 1'b0;
         buf_rd_q <= 5'd0;
         buf_wd_q <= 32'd0;
         cnt_q    <= '0;
         stall_q  <= 1'b0;
         rfwr_q   <= 1'b0;
         a3_q     <= 5'd0;
         wd_q     <= 32'd0;
      end else begin
         buf_v_q  <= buf_v_d;
         buf_rd_q <= buf_rd_d;
         buf_wd_q <= buf_wd_d;
         cnt_q    <= cnt_d;
         stall_q  <= stall_d;
         rfwr_q   <= rfwr_d;
         a3_q     <= a3_d;
         wd_q     <= wd_d;
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: hand-computed expectations checked after each edge.
module tb_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_rd;
   logic [31:0] pipe_wd;
   logic        mdu_valid;
   logic [4:0]  mdu_rd;
   logic [31:0] mdu_wd;
   logic        mdu_ready;
   logic        stall;
   logic        pend_valid;
   logic [4:0]  pend_rd;
   logic        RFWr;
   logic [4:0]  A3;
   logic [31:0] WD;

   int n_cmp  = 0;
   int n_fail = 0;

   wb_arbiter #(.STARVE_MAX(3)) dut (
      .clk        (clk),
      .rst        (rst),
      .pipe_we    (pipe_we),
      .pipe_rd    (pipe_rd),
      .pipe_wd    (pipe_wd),
      .mdu_valid  (mdu_valid),
      .mdu_rd     (mdu_rd),
      .mdu_wd     (mdu_wd),
      .mdu_ready  (mdu_ready),
      .stall      (stall),
      .pend_valid (pend_valid),
      .pend_rd    (pend_rd),
      .RFWr       (RFWr),
      .A3         (A3),
      .WD         (WD)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic we, input logic [4:0] a,
                         input logic [31:0] d);
      chk({tag, ".RFWr"}, 32'(RFWr), 32'(we));
      chk({tag, ".A3"}, 32'(A3), 32'(a));
      chk({tag, ".WD"}, WD, d);
   endtask

   initial begin
      rst = 1'b1; pipe_we = 1'b0; pipe_rd = 5'd0; pipe_wd = 32'd0;
      mdu_valid = 1'b0; mdu_rd = 5'd0; mdu_wd = 32'd0;
      step(); step();
      chk_wr("reset", 1'b0, 5'd0, 32'd0);
      chk("reset.stall", 32'(stall), 32'd0);
      chk("reset.pend_valid", 32'(pend_valid), 32'd0);
      chk("reset.mdu_ready", 32'(mdu_ready), 32'd0);
      rst = 1'b0; #1;
      chk("post_reset.mdu_ready", 32'(mdu_ready), 32'd1);

      // Pipe only
      pipe_we = 1'b1; pipe_rd = 5'd5; pipe_wd = 32'h11;
      step();
      chk_wr("pipe5", 1'b1, 5'd5, 32'h11);
      pipe_we = 1'b0;
      step();
      chk_wr("pipe_idle", 1'b0, 5'd0, 32'd0);

      // Idle pipe: mdu result buffered, then written
      mdu_valid = 1'b1; mdu_rd = 5'd7; mdu_wd = 32'hAB;
      step();
      mdu_valid = 1'b0;
      chk("mdu7.pend_valid", 32'(pend_valid), 32'd1);
      chk("mdu7.pend_rd", 32'(pend_rd), 32'd7);
      chk("mdu7.mdu_ready_full", 32'(mdu_ready), 32'd0);
      chk("mdu7.no_write_yet", 32'(RFWr), 32'd0);
      step();
      chk_wr("mdu7.write", 1'b1, 5'd7, 32'hAB);
      chk("mdu7.drained", 32'(pend_valid), 32'd0);
      chk("mdu7.mdu_ready_back", 32'(mdu_ready), 32'd1);

      // Starvation: buffer rd=9 under continuous pipe writes to rd=4
      pipe_we = 1'b1; pipe_rd = 5'd4; pipe_wd = 32'h44;
      mdu_valid = 1'b1; mdu_rd = 5'd9; mdu_wd = 32'h99;
      step();
      mdu_valid = 1'b0;
      chk_wr("starve.e0", 1'b1, 5'd4, 32'h44);
      chk("starve.e0.pend", 32'(pend_valid), 32'd1);
      step(); chk("starve.e1.stall", 32'(stall), 32'd0);
      step(); chk("starve.e2.stall", 32'(stall), 32'd0);
      step(); chk("starve.e3.stall", 32'(stall), 32'd0);
      chk("starve.e3.pend", 32'(pend_valid), 32'd1);
      step();
      chk("starve.e4.stall", 32'(stall), 32'd1);
      chk_wr("starve.e4", 1'b1, 5'd4, 32'h44);
      pipe_wd = 32'h55;
      step();
      chk("starve.e5.stall", 32'(stall), 32'd0);
      chk_wr("starve.e5.buf", 1'b1, 5'd9, 32'h99);
      chk("starve.e5.pend", 32'(pend_valid), 32'd0);
      step();
      chk_wr("starve.e6.replay", 1'b1, 5'd4, 32'h55);
      pipe_we = 1'b0;
      step();
      chk("starve.e7.stall", 32'(stall), 32'd0);
      chk_wr("starve.e7", 1'b0, 5'd0, 32'd0);

      // WAW squash
      pipe_we = 1'b1; pipe_rd = 5'd4; pipe_wd = 32'h10;
      mdu_valid = 1'b1; mdu_rd = 5'd6; mdu_wd = 32'h1;
      step();
      mdu_valid = 1'b0;
      chk("waw.pend_rd", 32'(pend_rd), 32'd6);
      pipe_rd = 5'd6; pipe_wd = 32'h2;
      step();
      chk_wr("waw.write", 1'b1, 5'd6, 32'h2);
      chk("waw.pend_valid", 32'(pend_valid), 32'd0);
      pipe_we = 1'b0;
      step(); chk("waw.no_stale1", 32'(RFWr), 32'd0);
      step(); chk("waw.no_stale2", 32'(RFWr), 32'd0);

      // x0: pipe rd=0 does not block the buffer
      pipe_we = 1'b1; pipe_rd = 5'd4; pipe_wd = 32'h20;
      mdu_valid = 1'b1; mdu_rd = 5'd3; mdu_wd = 32'h33;
      step();
      mdu_valid = 1'b0;
      chk("x0.pend_rd", 32'(pend_rd), 32'd3);
      pipe_rd = 5'd0; pipe_wd = 32'hFF;
      step();
      chk_wr("x0.buf_write", 1'b1, 5'd3, 32'h33);
      pipe_we = 1'b0;
      mdu_valid = 1'b1; mdu_rd = 5'd0; mdu_wd = 32'hDEAD;
      step();
      mdu_valid = 1'b0;
      chk("x0.mdu_rd0.pend", 32'(pend_valid), 32'd0);
      chk("x0.mdu_rd0.ready", 32'(mdu_ready), 32'd1);
      step();
      chk("x0.mdu_rd0.no_write", 32'(RFWr), 32'd0);

      // Same-rd accept alongside committed pipe write is discarded
      pipe_we = 1'b1; pipe_rd = 5'd12; pipe_wd = 32'hC0;
      mdu_valid = 1'b1; mdu_rd = 5'd12; mdu_wd = 32'hC1;
      step();
      mdu_valid = 1'b0; pipe_we = 1'b0;
      chk_wr("same_rd", 1'b1, 5'd12, 32'hC0);
      chk("same_rd.pend", 32'(pend_valid), 32'd0);
      step();
      chk("same_rd.no_write", 32'(RFWr), 32'd0);

      // Reset with buffer full drops the entry
      pipe_we = 1'b1; pipe_rd = 5'd4; pipe_wd = 32'h30;
      mdu_valid = 1'b1; mdu_rd = 5'd8; mdu_wd = 32'h88;
      step();
      mdu_valid = 1'b0; pipe_we = 1'b0;
      chk("rst_full.pend_rd", 32'(pend_rd), 32'd8);
      rst = 1'b1; #1;
      chk("rst_full.ready_in_rst", 32'(mdu_ready), 32'd0);
      step();
      chk_wr("rst_full.outs", 1'b0, 5'd0, 32'd0);
      chk("rst_full.pend", 32'(pend_valid), 32'd0);
      chk("rst_full.stall", 32'(stall), 32'd0);
      rst = 1'b0; #1;
      chk("rst_full.ready_after", 32'(mdu_ready), 32'd1);
      mdu_valid = 1'b1; mdu_rd = 5'd10; mdu_wd = 32'h77;
      step();
      mdu_valid = 1'b0;
      chk("rst_full.no_rd8", 32'(RFWr), 32'd0);
      chk("rst_full.first_accept", 32'(pend_rd), 32'd10);
      step();
      chk_wr("rst_full.write10", 1'b1, 5'd10, 32'h77);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
